// File: rtl/rv32i_types.sv
// Shared RV32I types: opcodes, the decoded control word, the ID/EX bundle
// and source-operand usage helpers.
package rv32i_types;

   localparam int unsigned XLEN_W = 32;
   localparam int unsigned RA_W_P = 5;

   typedef enum logic [6:0] {
      op_lui   = 7'b0110111,
      op_auipc = 7'b0010111,
      op_jal   = 7'b1101111,
      op_jalr  = 7'b1100111,
      op_br    = 7'b1100011,
      op_load  = 7'b0000011,
      op_store = 7'b0100011,
      op_imm   = 7'b0010011,
      op_reg   = 7'b0110011,
      op_csr   = 7'b1110011
   } rv32i_opcode;

   // An all-zero control word is the bubble encoding on the ID/EX register.
   typedef struct packed {
      rv32i_opcode opcode;
      logic [2:0]  funct3;
      logic [2:0]  alu_fn;
      logic        alu_alt;
      logic        alu_imm;
      logic        load_regfile;
      logic        mem_read;
      logic        mem_write;
   } rv32i_control_word;

   typedef struct packed {
      rv32i_control_word  ctrl;
      logic [XLEN_W-1:0]  rs1_data;
      logic [XLEN_W-1:0]  rs2_data;
      logic [RA_W_P-1:0]  rs1;
      logic [RA_W_P-1:0]  rs2;
      logic [RA_W_P-1:0]  rd;
      logic [XLEN_W-1:0]  inst;
      logic [XLEN_W-1:0]  pc;
      logic               is_branch;
   } id_ex_bundle_t;

   function automatic logic uses_rs1(input rv32i_opcode op);
      return !((op == op_lui) || (op == op_auipc) || (op == op_jal));
   endfunction

   function automatic logic uses_rs2(input rv32i_opcode op);
      return (op == op_br) || (op == op_store) || (op == op_reg);
   endfunction

endpackage

// File: rtl/control_rom.sv
// Opcode/funct decode into the RV32I control word; unknown opcodes decode
// to an all-zero word.
module control_rom
   import rv32i_types::*;
(
   input  rv32i_opcode       opcode,
   input  logic [2:0]        funct3,
   input  logic              funct7_b5,
   output rv32i_control_word ctrl
);

   always_comb begin
      ctrl        = '0;
      ctrl.opcode = opcode;
      ctrl.funct3 = funct3;
      case (opcode)
         op_lui, op_auipc, op_jal, op_jalr: begin
            ctrl.load_regfile = 1'b1;
            ctrl.alu_imm      = 1'b1;
         end
         op_br: ctrl.alu_alt = 1'b1;
         op_load: begin
            ctrl.load_regfile = 1'b1;
            ctrl.mem_read     = 1'b1;
            ctrl.alu_imm      = 1'b1;
         end
         op_store: begin
            ctrl.mem_write = 1'b1;
            ctrl.alu_imm   = 1'b1;
         end
         op_imm: begin
            ctrl.load_regfile = 1'b1;
            ctrl.alu_imm      = 1'b1;
            ctrl.alu_fn       = funct3;
            ctrl.alu_alt      = (funct3 == 3'b101) && funct7_b5;
         end
         op_reg: begin
            ctrl.load_regfile = 1'b1;
            ctrl.alu_fn       = funct3;
            ctrl.alu_alt      = funct7_b5;
         end
         op_csr: ctrl.load_regfile = 1'b1;
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/id_inst_fifo.sv
// Circular instruction queue between fetch and decode; full/empty come from
// the occupancy count, and flush empties it in one edge.
module id_inst_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 64,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             empty,
   output logic             full,
   output logic [CNT_W-1:0] occupancy
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok, pop_ok;

   assign empty     = (count_q == '0);
   assign full      = (count_q == CNT_W'(DEPTH));
   assign occupancy = count_q;
   assign rdata     = mem_q[rd_ptr_q];
   assign push_ok   = push && !full;
   assign pop_ok    = pop && !empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (pop_ok) rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/regfile.sv
// Architectural register file: one write port, two asynchronous read ports,
// x0 hard-wired to zero.
module regfile #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned NUM_REGS = 32,
   localparam int unsigned RA_W    = $clog2(NUM_REGS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic [RA_W-1:0] dest,
   input  logic [XLEN-1:0] in,
   input  logic [RA_W-1:0] src_a,
   input  logic [RA_W-1:0] src_b,
   output logic [XLEN-1:0] reg_a,
   output logic [XLEN-1:0] reg_b
);

   logic [XLEN-1:0] data_q [NUM_REGS];
   logic [XLEN-1:0] data_d [NUM_REGS];

   always_comb begin
      data_d = data_q;
      if (load && (dest != '0)) data_d[dest] = in;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) data_q[i] <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign reg_a = (src_a == '0) ? '0 : data_q[src_a];
   assign reg_b = (src_b == '0) ? '0 : data_q[src_b];

endmodule

// File: rtl/id_queue_stage.sv
// Decode stage: instruction queue, control decode, regfile read with
// write-through, load-use scoreboard and a valid/ready ID/EX register.
module id_queue_stage
   import rv32i_types::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned XLEN     = 32,
   parameter int unsigned NUM_REGS = 32,
   localparam int unsigned RA_W    = $clog2(NUM_REGS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     if_valid,
   output logic                     if_ready,
   input  logic [XLEN-1:0]          if_inst,
   input  logic [XLEN-1:0]          if_pc,
   input  logic                     flush,
   input  logic                     wb_load,
   input  logic [RA_W-1:0]          wb_rd,
   input  logic [XLEN-1:0]          wb_data,
   input  logic                     wb_is_load,
   input  logic                     ex_ready,
   output logic                     ex_valid,
   output rv32i_control_word        ex_ctrl,
   output logic [XLEN-1:0]          ex_rs1_data,
   output logic [XLEN-1:0]          ex_rs2_data,
   output logic [RA_W-1:0]          ex_rs1,
   output logic [RA_W-1:0]          ex_rs2,
   output logic [RA_W-1:0]          ex_rd,
   output logic [XLEN-1:0]          ex_inst,
   output logic [XLEN-1:0]          ex_pc,
   output logic                     ex_is_branch,
   output logic [$clog2(DEPTH):0]   occupancy
);

   logic [2*XLEN-1:0] head_data;
   logic [XLEN-1:0]   head_inst, head_pc;
   logic              fifo_empty, fifo_full, push, pop;

   rv32i_opcode       opcode;
   rv32i_control_word head_ctrl;
   logic [RA_W-1:0]   rs1, rs2, rd;
   logic [XLEN-1:0]   rf_a, rf_b, rs1_data, rs2_data;

   logic [NUM_REGS-1:0] sb_q, sb_d, sb_clr, sb_set;
   logic                hazard, issue;

   id_ex_bundle_t ex_q, ex_d;
   logic          ex_valid_q, ex_valid_d;

   // A flushing edge must not admit the younger instruction fetch presents.
   assign if_ready = !fifo_full;
   assign push     = if_valid && if_ready && !flush;
   assign pop      = issue;

   id_inst_fifo #(.DEPTH(DEPTH), .WIDTH(2*XLEN)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (pop),
      .flush     (flush),
      .wdata     ({if_pc, if_inst}),
      .rdata     (head_data),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .occupancy (occupancy)
   );

   assign {head_pc, head_inst} = head_data;
   assign opcode = rv32i_opcode'(head_inst[6:0]);
   assign rd     = head_inst[7 +: RA_W];
   assign rs1    = head_inst[15 +: RA_W];
   assign rs2    = head_inst[20 +: RA_W];

   control_rom u_rom (
      .opcode    (opcode),
      .funct3    (head_inst[14:12]),
      .funct7_b5 (head_inst[30]),
      .ctrl      (head_ctrl)
   );

   regfile #(.XLEN(XLEN), .NUM_REGS(NUM_REGS)) u_rf (
      .clk   (clk),
      .rst   (rst),
      .load  (wb_load),
      .dest  (wb_rd),
      .in    (wb_data),
      .src_a (rs1),
      .src_b (rs2),
      .reg_a (rf_a),
      .reg_b (rf_b)
   );

   // Same-cycle writeback is visible to the instruction issuing on that edge.
   assign rs1_data = (rs1 == '0) ? '0 : ((wb_load && (wb_rd == rs1)) ? wb_data : rf_a);
   assign rs2_data = (rs2 == '0) ? '0 : ((wb_load && (wb_rd == rs2)) ? wb_data : rf_b);

   always_comb begin
      sb_clr = '0;
      if (wb_load && wb_is_load) sb_clr[wb_rd] = 1'b1;

      hazard = (uses_rs1(opcode) && sb_q[rs1] && !sb_clr[rs1]) ||
               (uses_rs2(opcode) && sb_q[rs2] && !sb_clr[rs2]);
      issue  = !fifo_empty && !hazard && (ex_ready || !ex_valid_q) && !flush;

      sb_set = '0;
      if (issue && (opcode == op_load) && (rd != '0)) sb_set[rd] = 1'b1;
      // Set after clear so a same-edge re-issue of a load keeps the bit.
      sb_d    = (sb_q & ~sb_clr) | sb_set;
      sb_d[0] = 1'b0;
   end

   always_comb begin
      ex_d       = ex_q;
      ex_valid_d = ex_valid_q;
      if (flush) begin
         ex_d       = '0;
         ex_valid_d = 1'b0;
      end else if (issue) begin
         ex_d.ctrl      = head_ctrl;
         ex_d.rs1_data  = rs1_data;
         ex_d.rs2_data  = rs2_data;
         ex_d.rs1       = rs1;
         ex_d.rs2       = rs2;
         ex_d.rd        = rd;
         ex_d.inst      = head_inst;
         ex_d.pc        = head_pc;
         ex_d.is_branch = (opcode == op_br) || (opcode == op_jal) || (opcode == op_jalr);
         ex_valid_d     = 1'b1;
      end else if (ex_ready || !ex_valid_q) begin
         ex_d       = '0;
         ex_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sb_q       <= '0;
         ex_q       <= '0;
         ex_valid_q <= 1'b0;
      end else begin
         sb_q       <= sb_d;
         ex_q       <= ex_d;
         ex_valid_q <= ex_valid_d;
      end
   end

   assign ex_valid     = ex_valid_q;
   assign ex_ctrl      = ex_q.ctrl;
   assign ex_rs1_data  = ex_q.rs1_data;
   assign ex_rs2_data  = ex_q.rs2_data;
   assign ex_rs1       = ex_q.rs1;
   assign ex_rs2       = ex_q.rs2;
   assign ex_rd        = ex_q.rd;
   assign ex_inst      = ex_q.inst;
   assign ex_pc        = ex_q.pc;
   assign ex_is_branch = ex_q.is_branch;

endmodule
